// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the memory arbiter
package mem_arbiter_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [1:0]  len_t;

    typedef enum logic {
        OP_LD = 1'b0,
        OP_ST = 1'b1
    } op_t;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // addr[17:16] value that selects the IO region
    localparam logic [1:0] IO_ADDR_HI = 2'b11;

    localparam len_t LEN_BYTE = 2'b01;
    localparam len_t LEN_HALF = 2'b10;
    localparam len_t LEN_WORD = 2'b11;

    function automatic data_t len_mask(input len_t len);
        case (len)
            LEN_BYTE: len_mask = 32'h0000_00FF;
            LEN_HALF: len_mask = 32'h0000_FFFF;
            default:  len_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/LSB arbiter in front of the byte-serial memory controller
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clr_in,
    input  logic        io_buffer_full,
    input  logic        if_to_arb_req,
    input  addr_t       if_to_arb_pc,
    output logic        arb_to_if_done,
    output data_t       arb_to_if_inst,
    input  logic        lsb_to_arb_req,
    input  op_t         lsb_to_arb_opType,
    input  len_t        lsb_to_arb_len,
    input  addr_t       lsb_to_arb_addr,
    input  data_t       lsb_to_arb_data,
    output logic        arb_to_lsb_ld_done,
    output logic        arb_to_lsb_st_done,
    output data_t       arb_to_lsb_result,
    output logic        arb_to_mc_valid,
    output logic        arb_to_mc_wr,
    output len_t        arb_to_mc_len,
    output addr_t       arb_to_mc_addr,
    output data_t       arb_to_mc_data,
    input  logic        mc_to_arb_done,
    input  data_t       mc_to_arb_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SERVE_IF  = 2'd1,
        ST_SERVE_LSB = 2'd2,
        ST_DISCARD   = 2'd3
    } arb_state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    arb_state_t state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       valid_q, valid_d;
    logic       wr_q, wr_d;
    len_t       len_q, len_d;
    addr_t      addr_q, addr_d;
    data_t      data_q, data_d;
    logic       if_done_q, if_done_d;
    logic       ld_done_q, ld_done_d;
    logic       st_done_q, st_done_d;
    data_t      inst_q, inst_d;
    data_t      result_q, result_d;

    logic lsb_eligible;
    logic grant_if;
    logic grant_lsb;

    // An IO store must not be issued while the UART cannot accept it
    always_comb begin
        lsb_eligible = lsb_to_arb_req &&
                       !(lsb_to_arb_opType == OP_ST &&
                         lsb_to_arb_addr[17:16] == IO_ADDR_HI &&
                         io_buffer_full);
        grant_if  = if_to_arb_req && (starve_q == STARVE_MAX || !lsb_eligible);
        grant_lsb = lsb_eligible && !grant_if;
    end

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        valid_d   = valid_q;
        wr_d      = wr_q;
        len_d     = len_q;
        addr_d    = addr_q;
        data_d    = data_q;
        if_done_d = if_done_q;
        ld_done_d = ld_done_q;
        st_done_d = st_done_q;
        inst_d    = inst_q;
        result_d  = result_q;

        if (rdy_in) begin
            if_done_d = 1'b0;
            ld_done_d = 1'b0;
            st_done_d = 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (clr_in) begin
                        starve_d = 4'd0;
                    end else if (grant_if) begin
                        state_d  = ST_SERVE_IF;
                        valid_d  = 1'b1;
                        wr_d     = 1'b0;
                        len_d    = LEN_WORD;
                        addr_d   = if_to_arb_pc;
                        data_d   = '0;
                        starve_d = 4'd0;
                    end else if (grant_lsb) begin
                        state_d = ST_SERVE_LSB;
                        valid_d = 1'b1;
                        wr_d    = (lsb_to_arb_opType == OP_ST);
                        len_d   = lsb_to_arb_len;
                        addr_d  = lsb_to_arb_addr;
                        data_d  = lsb_to_arb_data;
                        if (!if_to_arb_req)
                            starve_d = 4'd0;
                        else if (starve_q != STARVE_MAX)
                            starve_d = starve_q + 4'd1;
                    end else if (!if_to_arb_req) begin
                        starve_d = 4'd0;
                    end
                end

                ST_SERVE_IF: begin
                    if (mc_to_arb_done) begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                        if (!clr_in) begin
                            if_done_d = 1'b1;
                            inst_d    = mc_to_arb_rdata;
                        end
                    end else if (clr_in) begin
                        state_d = ST_DISCARD;
                    end
                end

                ST_SERVE_LSB: begin
                    // A committed store always finishes, flush or not
                    if (wr_q) begin
                        if (mc_to_arb_done) begin
                            valid_d   = 1'b0;
                            state_d   = ST_IDLE;
                            st_done_d = 1'b1;
                        end
                    end else if (mc_to_arb_done) begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                        if (!clr_in) begin
                            ld_done_d = 1'b1;
                            result_d  = mc_to_arb_rdata & len_mask(len_q);
                        end
                    end else if (clr_in) begin
                        state_d = ST_DISCARD;
                    end
                end

                ST_DISCARD: begin
                    if (mc_to_arb_done) begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            starve_q  <= 4'd0;
            valid_q   <= 1'b0;
            wr_q      <= 1'b0;
            len_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            if_done_q <= 1'b0;
            ld_done_q <= 1'b0;
            st_done_q <= 1'b0;
            inst_q    <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            valid_q   <= valid_d;
            wr_q      <= wr_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            if_done_q <= if_done_d;
            ld_done_q <= ld_done_d;
            st_done_q <= st_done_d;
            inst_q    <= inst_d;
            result_q  <= result_d;
        end
    end

    assign arb_to_if_done     = if_done_q;
    assign arb_to_if_inst     = inst_q;
    assign arb_to_lsb_ld_done = ld_done_q;
    assign arb_to_lsb_st_done = st_done_q;
    assign arb_to_lsb_result  = result_q;
    assign arb_to_mc_valid    = valid_q;
    assign arb_to_mc_wr       = wr_q;
    assign arb_to_mc_len      = len_q;
    assign arb_to_mc_addr     = addr_q;
    assign arb_to_mc_data     = data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clr_in, io_buffer_full;
    logic        if_to_arb_req;
    addr_t       if_to_arb_pc;
    logic        arb_to_if_done;
    data_t       arb_to_if_inst;
    logic        lsb_to_arb_req;
    op_t         lsb_to_arb_opType;
    len_t        lsb_to_arb_len;
    addr_t       lsb_to_arb_addr;
    data_t       lsb_to_arb_data;
    logic        arb_to_lsb_ld_done, arb_to_lsb_st_done;
    data_t       arb_to_lsb_result;
    logic        arb_to_mc_valid, arb_to_mc_wr;
    len_t        arb_to_mc_len;
    addr_t       arb_to_mc_addr;
    data_t       arb_to_mc_data;
    logic        mc_to_arb_done;
    data_t       mc_to_arb_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_in = ~clk_in;

    mem_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
        .io_buffer_full(io_buffer_full),
        .if_to_arb_req(if_to_arb_req), .if_to_arb_pc(if_to_arb_pc),
        .arb_to_if_done(arb_to_if_done), .arb_to_if_inst(arb_to_if_inst),
        .lsb_to_arb_req(lsb_to_arb_req), .lsb_to_arb_opType(lsb_to_arb_opType),
        .lsb_to_arb_len(lsb_to_arb_len), .lsb_to_arb_addr(lsb_to_arb_addr),
        .lsb_to_arb_data(lsb_to_arb_data),
        .arb_to_lsb_ld_done(arb_to_lsb_ld_done), .arb_to_lsb_st_done(arb_to_lsb_st_done),
        .arb_to_lsb_result(arb_to_lsb_result),
        .arb_to_mc_valid(arb_to_mc_valid), .arb_to_mc_wr(arb_to_mc_wr),
        .arb_to_mc_len(arb_to_mc_len), .arb_to_mc_addr(arb_to_mc_addr),
        .arb_to_mc_data(arb_to_mc_data),
        .mc_to_arb_done(mc_to_arb_done), .mc_to_arb_rdata(mc_to_arb_rdata)
    );

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    // Controller response: done pulse lat cycles after valid was first seen
    task automatic mc_serve(input int lat, input data_t rd);
        repeat (lat - 1) cyc();
        mc_to_arb_done  = 1'b1;
        mc_to_arb_rdata = rd;
        cyc();
        mc_to_arb_done  = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0; io_buffer_full = 1'b0;
        if_to_arb_req = 1'b0; if_to_arb_pc = '0;
        lsb_to_arb_req = 1'b0; lsb_to_arb_opType = OP_LD; lsb_to_arb_len = 2'b00;
        lsb_to_arb_addr = '0; lsb_to_arb_data = '0;
        mc_to_arb_done = 1'b0; mc_to_arb_rdata = 32'hFFFF_FFFF;
        repeat (2) cyc();
        tests_run++;
        if ({arb_to_if_done, arb_to_lsb_ld_done, arb_to_lsb_st_done, arb_to_mc_valid, arb_to_mc_wr} !== 5'b0 ||
            arb_to_mc_len !== 2'b00 || arb_to_mc_addr !== 32'h0 || arb_to_mc_data !== 32'h0 ||
            arb_to_if_inst !== 32'h0 || arb_to_lsb_result !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_state: valid=%b addr=%h inst=%h result=%h, required all zero",
                     arb_to_mc_valid, arb_to_mc_addr, arb_to_if_inst, arb_to_lsb_result);
        end
        rst_in = 1'b0;
        cyc();
    endtask

    task automatic test_if_fetch();
        if_to_arb_req = 1'b1; if_to_arb_pc = 32'h0000_0004;
        cyc();
        tests_run++;
        if (arb_to_mc_valid !== 1'b1 || arb_to_mc_addr !== 32'h4 || arb_to_mc_len !== 2'b11 || arb_to_mc_wr !== 1'b0) begin
            tests_failed++;
            $display("FAIL if_issue: valid=%b addr=%h len=%b wr=%b, required 1 00000004 11 0",
                     arb_to_mc_valid, arb_to_mc_addr, arb_to_mc_len, arb_to_mc_wr);
        end
        repeat (4) cyc();
        tests_run++;
        if (arb_to_mc_valid !== 1'b1 || arb_to_mc_addr !== 32'h4 || arb_to_if_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL if_hold: valid=%b addr=%h done=%b, required 1 00000004 0",
                     arb_to_mc_valid, arb_to_mc_addr, arb_to_if_done);
        end
        mc_to_arb_done = 1'b1; mc_to_arb_rdata = 32'h0051_3023;
        cyc();
        mc_to_arb_done = 1'b0;
        tests_run++;
        if (arb_to_if_done !== 1'b1 || arb_to_if_inst !== 32'h0051_3023 || arb_to_mc_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL if_done: done=%b inst=%h valid=%b, required 1 00513023 0",
                     arb_to_if_done, arb_to_if_inst, arb_to_mc_valid);
        end
        if_to_arb_req = 1'b0;
        cyc();
        tests_run++;
        if (arb_to_if_done !== 1'b0 || arb_to_mc_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL if_done_once: done=%b valid=%b, required 0 0", arb_to_if_done, arb_to_mc_valid);
        end
    endtask

    task automatic test_priority();
        if_to_arb_req = 1'b1; if_to_arb_pc = 32'h0000_0008;
        lsb_to_arb_req = 1'b1; lsb_to_arb_opType = OP_LD; lsb_to_arb_len = 2'b01;
        lsb_to_arb_addr = 32'h0000_0100;
        cyc();
        tests_run++;
        if (arb_to_mc_valid !== 1'b1 || arb_to_mc_addr !== 32'h100 || arb_to_mc_len !== 2'b01) begin
            tests_failed++;
            $display("FAIL lsb_first: valid=%b addr=%h len=%b, required 1 00000100 01",
                     arb_to_mc_valid, arb_to_mc_addr, arb_to_mc_len);
        end
        mc_serve(3, 32'hDEAD_BEEF);
        tests_run++;
        if (arb_to_lsb_ld_done !== 1'b1 || arb_to_lsb_result !== 32'h0000_00EF || arb_to_if_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL byte_load: ld_done=%b result=%h if_done=%b, required 1 000000ef 0",
                     arb_to_lsb_ld_done, arb_to_lsb_result, arb_to_if_done);
        end
        lsb_to_arb_req = 1'b0;
        cyc();
        tests_run++;
        if (arb_to_mc_valid !== 1'b1 || arb_to_mc_addr !== 32'h8) begin
            tests_failed++;
            $display("FAIL if_second: valid=%b addr=%h, required 1 00000008", arb_to_mc_valid, arb_to_mc_addr);
        end
        mc_serve(2, 32'h1234_5678);
        if_to_arb_req = 1'b0;
        cyc();
    endtask

    task automatic test_starvation();
        addr_t exp_addr [0:5];
        int n;
        exp_addr[0] = 32'h300; exp_addr[1] = 32'h300; exp_addr[2] = 32'h300;
        exp_addr[3] = 32'h300; exp_addr[4] = 32'h200; exp_addr[5] = 32'h300;
        if_to_arb_req = 1'b1; if_to_arb_pc = 32'h0000_0200;
        lsb_to_arb_req = 1'b1; lsb_to_arb_opType = OP_LD; lsb_to_arb_len = 2'b11;
        lsb_to_arb_addr = 32'h0000_0300;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            do begin
                cyc();
                n++;
            end while (arb_to_mc_valid !== 1'b1 && n < 20);
            tests_run++;
            if (arb_to_mc_valid !== 1'b1 || arb_to_mc_addr !== exp_addr[k]) begin
                tests_failed++;
                $display("FAIL starve_grant_%0d: valid=%b addr=%h, required 1 %h",
                         k, arb_to_mc_valid, arb_to_mc_addr, exp_addr[k]);
            end
            mc_serve(2, 32'h0);
        end
        if_to_arb_req = 1'b0; lsb_to_arb_req = 1'b0;
        cyc();
    endtask

    task automatic test_io_full();
        int bad;
        bad = 0;
        io_buffer_full = 1'b1;
        lsb_to_arb_req = 1'b1; lsb_to_arb_opType = OP_ST; lsb_to_arb_len = 2'b11;
        lsb_to_arb_addr = 32'h0003_0000; lsb_to_arb_data = 32'h0000_0041;
        if_to_arb_req = 1'b1; if_to_arb_pc = 32'h0000_0400;
        cyc();
        tests_run++;
        if (arb_to_mc_valid !== 1'b1 || arb_to_mc_addr !== 32'h400 || arb_to_mc_wr !== 1'b0) begin
            tests_failed++;
            $display("FAIL io_if_wins: valid=%b addr=%h wr=%b, required 1 00000400 0",
                     arb_to_mc_valid, arb_to_mc_addr, arb_to_mc_wr);
        end
        mc_serve(2, 32'hAAAA_5555);
        tests_run++;
        if (arb_to_if_done !== 1'b1 || arb_to_if_inst !== 32'hAAAA_5555) begin
            tests_failed++;
            $display("FAIL io_if_done: done=%b inst=%h, required 1 aaaa5555", arb_to_if_done, arb_to_if_inst);
        end
        if_to_arb_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (arb_to_mc_valid !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL io_store_held: %0d cycles with valid high, required 0", bad);
        end
        io_buffer_full = 1'b0;
        cyc();
        tests_run++;
        if (arb_to_mc_valid !== 1'b1 || arb_to_mc_wr !== 1'b1 || arb_to_mc_addr !== 32'h0003_0000 ||
            arb_to_mc_data !== 32'h41) begin
            tests_failed++;
            $display("FAIL io_store_issue: valid=%b wr=%b addr=%h data=%h, required 1 1 00030000 00000041",
                     arb_to_mc_valid, arb_to_mc_wr, arb_to_mc_addr, arb_to_mc_data);
        end
        mc_serve(3, 32'h0);
        tests_run++;
        if (arb_to_lsb_st_done !== 1'b1 || arb_to_lsb_ld_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL io_st_done: st=%b ld=%b, required 1 0", arb_to_lsb_st_done, arb_to_lsb_ld_done);
        end
        lsb_to_arb_req = 1'b0;
        cyc();
        tests_run++;
        if (arb_to_lsb_st_done !== 1'b0 || arb_to_mc_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL io_st_once: st=%b valid=%b, required 0 0", arb_to_lsb_st_done, arb_to_mc_valid);
        end
    endtask

    task automatic test_clear();
        if_to_arb_req = 1'b1; if_to_arb_pc = 32'h0000_0500;
        cyc();
        cyc();
        clr_in = 1'b1; if_to_arb_req = 1'b0;
        cyc();
        clr_in = 1'b0;
        tests_run++;
        if (arb_to_mc_valid !== 1'b1 || arb_to_mc_addr !== 32'h500) begin
            tests_failed++;
            $display("FAIL discard_valid: valid=%b addr=%h, required 1 00000500", arb_to_mc_valid, arb_to_mc_addr);
        end
        cyc();
        mc_to_arb_done = 1'b1; mc_to_arb_rdata = 32'h0000_0BAD;
        cyc();
        mc_to_arb_done = 1'b0;
        tests_run++;
        if (arb_to_if_done !== 1'b0 || arb_to_mc_valid !== 1'b0 || arb_to_if_inst !== 32'hAAAA_5555) begin
            tests_failed++;
            $display("FAIL clr_if: done=%b valid=%b inst=%h, required 0 0 aaaa5555",
                     arb_to_if_done, arb_to_mc_valid, arb_to_if_inst);
        end
        lsb_to_arb_req = 1'b1; lsb_to_arb_opType = OP_ST; lsb_to_arb_len = 2'b10;
        lsb_to_arb_addr = 32'h0000_1000; lsb_to_arb_data = 32'h0000_1234;
        cyc();
        cyc();
        clr_in = 1'b1;
        cyc();
        clr_in = 1'b0;
        mc_serve(2, 32'h0);
        tests_run++;
        if (arb_to_lsb_st_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL clr_store: st_done=%b, required 1", arb_to_lsb_st_done);
        end
        lsb_to_arb_req = 1'b0;
        cyc();
    endtask

    task automatic test_clr_with_done();
        lsb_to_arb_req = 1'b1; lsb_to_arb_opType = OP_LD; lsb_to_arb_len = 2'b10;
        lsb_to_arb_addr = 32'h0000_0600;
        cyc();
        cyc();
        mc_to_arb_done = 1'b1; mc_to_arb_rdata = 32'h1111_2222; clr_in = 1'b1; lsb_to_arb_req = 1'b0;
        cyc();
        mc_to_arb_done = 1'b0; clr_in = 1'b0;
        tests_run++;
        if (arb_to_lsb_ld_done !== 1'b0 || arb_to_mc_valid !== 1'b0 || arb_to_lsb_result !== 32'h0) begin
            tests_failed++;
            $display("FAIL clr_done_load: ld=%b valid=%b result=%h, required 0 0 00000000",
                     arb_to_lsb_ld_done, arb_to_mc_valid, arb_to_lsb_result);
        end
        if_to_arb_req = 1'b1; if_to_arb_pc = 32'h0000_0700;
        cyc();
        tests_run++;
        if (arb_to_mc_valid !== 1'b1 || arb_to_mc_addr !== 32'h700) begin
            tests_failed++;
            $display("FAIL clr_done_idle: valid=%b addr=%h, required 1 00000700", arb_to_mc_valid, arb_to_mc_addr);
        end
        mc_serve(2, 32'h0000_0077);
        if_to_arb_req = 1'b0;
        cyc();
    endtask

    task automatic test_rdy_stall();
        int held;
        held = 0;
        lsb_to_arb_req = 1'b1; lsb_to_arb_opType = OP_LD; lsb_to_arb_len = 2'b10;
        lsb_to_arb_addr = 32'h0000_0800;
        cyc();
        mc_serve(2, 32'hCAFE_F00D);
        tests_run++;
        if (arb_to_lsb_ld_done !== 1'b1 || arb_to_lsb_result !== 32'h0000_F00D) begin
            tests_failed++;
            $display("FAIL half_load: ld=%b result=%h, required 1 0000f00d", arb_to_lsb_ld_done, arb_to_lsb_result);
        end
        rdy_in = 1'b0; lsb_to_arb_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            if (arb_to_lsb_ld_done === 1'b1) held++;
        end
        rdy_in = 1'b1;
        tests_run++;
        if (held != 3 || arb_to_lsb_ld_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL rdy_hold: held %0d cycles, done=%b, required 3 and 1", held, arb_to_lsb_ld_done);
        end
        cyc();
        tests_run++;
        if (arb_to_lsb_ld_done !== 1'b0 || arb_to_mc_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rdy_release: ld=%b valid=%b, required 0 0", arb_to_lsb_ld_done, arb_to_mc_valid);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_if_fetch();
        test_priority();
        test_starvation();
        test_io_full();
        test_clear();
        test_clr_with_done();
        test_rdy_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
